mux_select_scanner: RTL and testbench

//  Upstream sequencer for the 4-to-1 mux (mux_4to1). Drives its select lines

---
 rtl/mux_select_scanner.sv | 104 ++++++++++
 tb/tb_mux_select_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_scanner.sv
// Round-robin select sequencer for a 4-to-1 mux.
// Reassembles the serialised mux output into 4-bit frames behind a valid/ready port.
module mux_select_scanner #(
   parameter int DWELL = 2,
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       continuous,
   output logic [1:0] select,
   input  logic       mux_out,
   output logic [3:0] frame,
   output logic       frame_valid,
   input  logic       frame_ready,
   output logic       busy,
   output logic       overrun
);

   typedef enum logic {IDLE, SCAN} state_e;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   state_e           state_q;
   logic [1:0]       ch_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       buf_q;
   logic [1:0]       sel_q;
   logic [3:0]       frame_q;
   logic             fv_q;
   logic             busy_q;
   logic             ovr_q;

   logic             accept;
   logic [3:0]       word;

   assign accept = fv_q && frame_ready;
   assign word   = {mux_out, buf_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ch_q    <= 2'd0;
         cnt_q   <= '0;
         buf_q   <= 3'd0;
         sel_q   <= 2'd0;
         frame_q <= 4'd0;
         fv_q    <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         // Completion below may re-assert valid on the same edge.
         if (accept) begin
            fv_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               sel_q  <= 2'd0;
               busy_q <= 1'b0;
               if (start) begin
                  state_q <= SCAN;
                  ch_q    <= 2'd0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  ovr_q   <= 1'b0;
               end
            end
            SCAN: begin
               if (cnt_q == LAST) begin
                  cnt_q <= '0;
                  if (ch_q != 2'd3) begin
                     buf_q[ch_q] <= mux_out;
                     ch_q        <= ch_q + 2'd1;
                     sel_q       <= ch_q + 2'd1;
                  end else begin
                     if (!fv_q || frame_ready) begin
                        frame_q <= word;
                        fv_q    <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                     ch_q  <= 2'd0;
                     sel_q <= 2'd0;
                     if (!continuous) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign select      = sel_q;
   assign frame       = frame_q;
   assign frame_valid = fv_q;
   assign busy        = busy_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_mux_select_scanner.sv
// Bench for mux_select_scanner driving a behavioural 4-to-1 mux.
// Covers DWELL=2 and DWELL=1 builds.
module tb_mux_select_scanner;

   logic       clk;
   logic       rst_n;

   logic       start0, cont0, ready0, mux0;
   logic [3:0] data0;
   logic [1:0] sel0;
   logic [3:0] frame0;
   logic       fv0, busy0, ovr0;

   logic       start1, cont1, ready1, mux1;
   logic [3:0] data1;
   logic [1:0] sel1;
   logic [3:0] frame1;
   logic       fv1, busy1, ovr1;

   int checks   = 0;
   int failures = 0;

   logic [3:0] sb_q[$];
   logic [3:0] exp_w;

   assign mux0 = data0[sel0];
   assign mux1 = data1[sel1];

   mux_select_scanner #(.DWELL(2), .CNT_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .continuous(cont0),
      .select(sel0), .mux_out(mux0), .frame(frame0), .frame_valid(fv0),
      .frame_ready(ready0), .busy(busy0), .overrun(ovr0)
   );

   mux_select_scanner #(.DWELL(1), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .continuous(cont1),
      .select(sel1), .mux_out(mux1), .frame(frame1), .frame_valid(fv1),
      .frame_ready(ready1), .busy(busy1), .overrun(ovr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({sel0, busy0, fv0, frame0, ovr0} !== 9'd0) begin
         failures++;
         $display("FAIL reset_state got=%b want=0", {sel0, busy0, fv0, frame0, ovr0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      data0 = 4'b1111;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      tick();
      tick();
      checks++;
      if (sel0 !== 2'd1 || busy0 !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_scan sel=%0d busy=%b want sel=1 busy=1", sel0, busy0);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (sel0 !== 2'd0 || busy0 !== 1'b0 || fv0 !== 1'b0) begin
         failures++;
         $display("FAIL async_reset sel=%0d busy=%b fv=%b want 0 0 0", sel0, busy0, fv0);
      end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      checks++;
      if (busy0 !== 1'b0 || fv0 !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset busy=%b fv=%b want 0 0", busy0, fv0);
      end
   endtask

   task automatic test_single_scan();
      logic [1:0] exp_sel [8];
      exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
      data0  = 4'b1010;
      ready0 = 1'b1;
      cont0  = 1'b0;
      sb_q.push_back(4'b1010);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (sel0 !== exp_sel[k]) begin
            failures++;
            $display("FAIL select_seq[%0d] got=%0d want=%0d", k, sel0, exp_sel[k]);
         end
         tick();
      end
      checks++;
      if (fv0 !== 1'b1 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL single_done fv=%b busy=%b want 1 0", fv0, busy0);
      end
      if (fv0 === 1'b1 && sb_q.size() > 0) begin
         exp_w = sb_q.pop_front();
         checks++;
         if (frame0 !== exp_w) begin
            failures++;
            $display("FAIL single_frame got=%b want=%b", frame0, exp_w);
         end
      end
      tick();
      checks++;
      if (fv0 !== 1'b0) begin
         failures++;
         $display("FAIL single_consumed fv=%b want 0", fv0);
      end
   endtask

   task automatic test_backpressure();
      sb_q.delete();
      data0  = 4'b1100;
      ready0 = 1'b0;
      cont0  = 1'b1;
      sb_q.push_back(4'b1100);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (fv0 !== 1'b1 || frame0 !== 4'b1100 || ovr0 !== 1'b0) begin
         failures++;
         $display("FAIL bp_first fv=%b frame=%b ovr=%b want 1 1100 0", fv0, frame0, ovr0);
      end
      data0 = 4'b0101;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (fv0 !== 1'b1 || frame0 !== 4'b1100 || ovr0 !== 1'b1 || busy0 !== 1'b1) begin
         failures++;
         $display("FAIL bp_overrun fv=%b frame=%b ovr=%b busy=%b want 1 1100 1 1",
                  fv0, frame0, ovr0, busy0);
      end
      cont0 = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (busy0 !== 1'b0 || frame0 !== 4'b1100) begin
         failures++;
         $display("FAIL bp_stop busy=%b frame=%b want 0 1100", busy0, frame0);
      end
      ready0 = 1'b1;
      if (fv0 === 1'b1 && sb_q.size() > 0) begin
         exp_w = sb_q.pop_front();
         checks++;
         if (frame0 !== exp_w) begin
            failures++;
            $display("FAIL bp_drain got=%b want=%b", frame0, exp_w);
         end
      end else begin
         checks++;
         failures++;
         $display("FAIL bp_drain fv=%b want 1", fv0);
      end
      tick();
      checks++;
      if (fv0 !== 1'b0 || ovr0 !== 1'b1) begin
         failures++;
         $display("FAIL bp_sticky fv=%b ovr=%b want 0 1", fv0, ovr0);
      end
   endtask

   task automatic test_back_to_back();
      sb_q.delete();
      data0  = 4'b0110;
      ready0 = 1'b1;
      cont0  = 1'b1;
      sb_q.push_back(4'b0110);
      sb_q.push_back(4'b0110);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      checks++;
      if (ovr0 !== 1'b0 || busy0 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_start ovr=%b busy=%b want 0 1", ovr0, busy0);
      end
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (e == 9) cont0 = 1'b0;
         if (e == 8 || e == 16) begin
            checks++;
            if (fv0 !== 1'b1 || sb_q.size() == 0) begin
               failures++;
               $display("FAIL b2b_valid_%0d fv=%b want 1", e, fv0);
            end else begin
               exp_w = sb_q.pop_front();
               checks++;
               if (frame0 !== exp_w) begin
                  failures++;
                  $display("FAIL b2b_frame_%0d got=%b want=%b", e, frame0, exp_w);
               end
            end
         end
         if (e == 9) begin
            checks++;
            if (fv0 !== 1'b0 || busy0 !== 1'b1) begin
               failures++;
               $display("FAIL b2b_between fv=%b busy=%b want 0 1", fv0, busy0);
            end
         end
      end
      checks++;
      if (ovr0 !== 1'b0 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end ovr=%b busy=%b want 0 0", ovr0, busy0);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (busy0 !== 1'b0 || sel0 !== 2'd0) begin
         failures++;
         $display("FAIL b2b_idle busy=%b sel=%0d want 0 0", busy0, sel0);
      end
   endtask

   task automatic test_dwell1();
      sb_q.delete();
      data1  = 4'b1001;
      ready1 = 1'b0;
      cont1  = 1'b0;
      sb_q.push_back(4'b1001);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (sel1 !== 2'(k)) begin
            failures++;
            $display("FAIL d1_select[%0d] got=%0d want=%0d", k, sel1, k);
         end
         start1 = (k == 1);
         tick();
      end
      start1 = 1'b0;
      checks++;
      if (fv1 !== 1'b1 || busy1 !== 1'b0 || sb_q.size() == 0) begin
         failures++;
         $display("FAIL d1_done fv=%b busy=%b want 1 0", fv1, busy1);
      end else begin
         exp_w = sb_q.pop_front();
         checks++;
         if (frame1 !== exp_w) begin
            failures++;
            $display("FAIL d1_frame got=%b want=%b", frame1, exp_w);
         end
      end
      tick();
      tick();
      checks++;
      if (busy1 !== 1'b0 || fv1 !== 1'b1 || frame1 !== 4'b1001) begin
         failures++;
         $display("FAIL d1_idle busy=%b fv=%b frame=%b want 0 1 1001", busy1, fv1, frame1);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      start0 = 1'b0;
      cont0  = 1'b0;
      ready0 = 1'b0;
      data0  = 4'd0;
      start1 = 1'b0;
      cont1  = 1'b0;
      ready1 = 1'b0;
      data1  = 4'd0;
      test_reset();
      test_single_scan();
      test_backpressure();
      test_back_to_back();
      test_dwell1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
